uart_tx: RTL

//  Serialises bytes onto a UART line for the serial receiver in this bring-up section.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and bit-ordering helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_DATA_W = 8;
    localparam logic UART_IDLE   = 1'b1;
    localparam logic UART_START  = 1'b0;

    // The bit currently presented on the line is always at the shift-out end.
    function automatic logic line_bit(input logic [UART_DATA_W-1:0] shift, input logic msb_first);
        line_bit = msb_first ? shift[UART_DATA_W-1] : shift[0];
    endfunction

    function automatic logic [UART_DATA_W-1:0] shift_next(input logic [UART_DATA_W-1:0] shift,
                                                          input logic msb_first);
        shift_next = msb_first ? {shift[UART_DATA_W-2:0], 1'b0} : {1'b0, shift[UART_DATA_W-1:1]};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last clk of each CLKS_PER_BIT-long bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int            CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Reload at every bit boundary so each bit starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, one-entry holding register, framed serial output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   tx,
    output logic                   busy
);
    localparam logic MSB_F     = (MSB_FIRST != 0);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   ready_q, ready_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   tick_s;
    logic                   load_s;
    logic                   accept_s;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick_s)
    );

    // Next-state, counters, shift/holding registers and registered line level.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        load_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (!tick_s) begin
                    state_d = DATA;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = shift_next(shift_q, MSB_F);
                end
            end
            STOP: begin
                if (!tick_s) begin
                    state_d = STOP;
                end else if (stop_cnt_q != STOP_LAST) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end else if (hold_full_q) begin
                    // Chain straight into the next frame with no idle gap.
                    state_d = START;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            shift_d = hold_q;
        end else begin
            shift_d = shift_d;
        end

        accept_s = valid && ready_q;
        hold_d   = accept_s ? data : hold_q;
        if (accept_s) begin
            hold_full_d = 1'b1;
        end else if (load_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        ready_d = !hold_full_d;
        busy_d  = (state_d != IDLE);

        case (state_d)
            START:   tx_d = UART_START;
            DATA:    tx_d = line_bit(shift_d, MSB_F);
            default: tx_d = UART_IDLE;
        endcase
    end

    // State and datapath registers; reset truncates any frame and drops the held byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            tx_q        <= UART_IDLE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign busy  = busy_q;

endmodule
